// File: rtl/demux.sv
// demux: pipelined 1-to-N demultiplexer built as a tree of registered BR-way stages.
// A word qualified by din_valid is steered to output adr and appears LAT cycles later
// as dout[adr] together with a one-cycle dout_valid[adr] strobe.
// Optional feature macro: DEMUX_ADR_CHECK_EN adds the sticky out-of-range flag adr_err.
module demux #(
    parameter  int N    = 64,
    parameter  int W    = 8,
    parameter  int BR   = 8,
    localparam int ADRB = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [W-1:0]    din,
    input  logic            din_valid,
    input  logic [ADRB-1:0] adr,
    output logic [W-1:0]    dout [N],
    output logic [N-1:0]    dout_valid
`ifdef DEMUX_ADR_CHECK_EN
    ,
    output logic            adr_err
`endif
);

    if (!((N % BR == 0) || (N <= BR))) begin : g_bad_cfg
        $error("demux: N (%0d) must be a multiple of BR (%0d) or not exceed it", N, BR);
    end

    if (N <= BR) begin : g_leaf

        // Final stage: decode the address straight into the per-output registers.
        // Unaddressed outputs keep their word; the strobe is rebuilt every cycle.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_valid <= '0;
                for (int k = 0; k < N; k++) begin
                    dout[k] <= '0;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    dout_valid[k] <= din_valid && (adr == ADRB'(k));
                    if (din_valid && (adr == ADRB'(k))) begin
                        dout[k] <= din;
                    end
                end
            end
        end

`ifdef DEMUX_ADR_CHECK_EN
        logic err_q;

        // Remember any valid transfer whose address lies beyond the last output.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (din_valid && (int'(adr) >= N)) begin
                err_q <= 1'b1;
            end
        end

        assign adr_err = err_q;
`endif

    end else begin : g_tree

        localparam int CB = $clog2(BR);
        localparam int NG = N / BR;
        localparam int GB = ADRB - CB;

        logic [NG-1:0] grp_valid;
        logic [W-1:0]  s1_din;
        logic [CB-1:0] s1_adr;
        logic [GB-1:0] grp;

        // Upper address bits pick the group; a group index past NG matches nothing,
        // so out-of-range transfers die here without touching any output.
        assign grp = adr[ADRB-1:CB];

        // First stage: forward the valid bit only to the addressed group.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                grp_valid <= '0;
            end else begin
                for (int g = 0; g < NG; g++) begin
                    grp_valid[g] <= din_valid && (grp == GB'(g));
                end
            end
        end

        // First-stage payload is shared by all groups and only captured on a transfer;
        // it is qualified by grp_valid downstream, so it needs no reset.
        always_ff @(posedge clk) begin
            if (din_valid) begin
                s1_din <= din;
                s1_adr <= adr[CB-1:0];
            end
        end

`ifdef DEMUX_ADR_CHECK_EN
        logic          err_q;
        logic [NG-1:0] sub_err;

        // Flag a valid transfer whose full address is beyond the last output.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                err_q <= 1'b0;
            end else if (din_valid && (int'(adr) >= N)) begin
                err_q <= 1'b1;
            end
        end

        assign adr_err = err_q | (|sub_err);
`endif

        for (genvar g = 0; g < NG; g++) begin : g_grp
            logic [W-1:0]  sub_dout [BR];
            logic [BR-1:0] sub_valid;

            demux #(
                .N  (BR),
                .W  (W),
                .BR (BR)
            ) u_sub (
                .clk        (clk),
                .rst        (rst),
                .din        (s1_din),
                .din_valid  (grp_valid[g]),
                .adr        (s1_adr),
                .dout       (sub_dout),
                .dout_valid (sub_valid)
`ifdef DEMUX_ADR_CHECK_EN
                ,
                .adr_err    (sub_err[g])
`endif
            );

            assign dout_valid[g*BR +: BR] = sub_valid;

            for (genvar j = 0; j < BR; j++) begin : g_out
                assign dout[g*BR + j] = sub_dout[j];
            end
        end

    end

endmodule

// File: tb/tb_demux.sv
// tb_demux: self-checking bench for the demux tree. The main instance (N=64, BR=8) is
// checked through a scoreboard of expected strobes; a degenerate instance (N=4) and a
// non-power-of-two instance (N=24) are checked directly.
module tb_demux;

    typedef struct {
        int         adr;
        logic [7:0] din;
        int         due;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;

    // main instance, N=64, BR=8, LAT=2
    logic [7:0]  din = '0;
    logic        din_valid = 1'b0;
    logic [5:0]  adr = '0;
    logic [7:0]  dout [64];
    logic [63:0] dout_valid;

    // degenerate instance, N=4, BR=8, LAT=1
    logic [7:0]  s_din = '0;
    logic        s_valid = 1'b0;
    logic [1:0]  s_adr = '0;
    logic [7:0]  s_dout [4];
    logic [3:0]  s_dv;

    // non-power-of-two instance, N=24, BR=8, LAT=2
    logic [7:0]  e_din = '0;
    logic        e_valid = 1'b0;
    logic [4:0]  e_adr = '0;
    logic [7:0]  e_dout [24];
    logic [23:0] e_dv;

`ifdef DEMUX_ADR_CHECK_EN
    logic m_err;
    logic s_err;
    logic e_err;
`endif

    exp_t       sb [$];
    logic [7:0] mdl [64];
    int         nCompared = 0;
    int         nMismatched = 0;

    localparam int LAT = 2;

    demux #(.N(64), .W(8), .BR(8)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .adr        (adr),
        .dout       (dout),
        .dout_valid (dout_valid)
`ifdef DEMUX_ADR_CHECK_EN
        ,
        .adr_err    (m_err)
`endif
    );

    demux #(.N(4), .W(8), .BR(8)) u_small (
        .clk        (clk),
        .rst        (rst),
        .din        (s_din),
        .din_valid  (s_valid),
        .adr        (s_adr),
        .dout       (s_dout),
        .dout_valid (s_dv)
`ifdef DEMUX_ADR_CHECK_EN
        ,
        .adr_err    (s_err)
`endif
    );

    demux #(.N(24), .W(8), .BR(8)) u_odd (
        .clk        (clk),
        .rst        (rst),
        .din        (e_din),
        .din_valid  (e_valid),
        .adr        (e_adr),
        .dout       (e_dout),
        .dout_valid (e_dv)
`ifdef DEMUX_ADR_CHECK_EN
        ,
        .adr_err    (e_err)
`endif
    );

    // free-running clock and edge counter
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // number of main-instance outputs that differ from the model
    function automatic int countDiff();
        int n = 0;
        for (int k = 0; k < 64; k++) begin
            if (dout[k] !== mdl[k]) n++;
        end
        return n;
    endfunction

    // drive one transfer for one cycle and record the expected strobe; valid stays up
    // so consecutive calls stream back-to-back
    task automatic applyStimulus(input int a, input logic [7:0] d);
        adr       = a[5:0];
        din       = d;
        din_valid = 1'b1;
        sb.push_back('{adr: a, din: d, due: cyc + LAT});
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        din_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // scoreboard monitor on the falling edge, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            while (sb.size() > 0 && sb[0].due < cyc) begin
                checkOutput("strobe_late", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end
            if (dout_valid != '0) begin
                checkOutput("strobe_onehot", 64'($onehot(dout_valid)), 64'd1);
                if (sb.size() == 0) begin
                    checkOutput("strobe_spurious", dout_valid, 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    checkOutput("strobe_idx", dout_valid, 64'd1 << e.adr);
                    checkOutput("strobe_data", 64'(dout[e.adr]), 64'(e.din));
                    checkOutput("strobe_cycle", 64'(cyc), 64'(e.due));
                    mdl[e.adr] = e.din;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        for (int k = 0; k < 64; k++) mdl[k] = '0;

        // reset held with random valid traffic on every input
        rst       = 1'b1;
        din_valid = 1'b1;
        s_valid   = 1'b1;
        e_valid   = 1'b1;
        repeat (4) begin
            din   = 8'($urandom);
            adr   = 6'($urandom);
            s_din = 8'($urandom);
            s_adr = 2'($urandom);
            e_din = 8'($urandom);
            e_adr = 5'($urandom_range(0, 23));
            @(posedge clk);
            #1;
        end
        checkOutput("reset_valid", dout_valid, 64'd0);
        checkOutput("reset_dout", 64'(countDiff()), 64'd0);
        checkOutput("reset_small_valid", 64'(s_dv), 64'd0);
        checkOutput("reset_small_dout3", 64'(s_dout[3]), 64'd0);
        checkOutput("reset_odd_valid", 64'(e_dv), 64'd0);
`ifdef DEMUX_ADR_CHECK_EN
        checkOutput("reset_adr_err", 64'(e_err), 64'd0);
`endif
        rst       = 1'b0;
        din_valid = 1'b0;
        s_valid   = 1'b0;
        e_valid   = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
            checkOutput("idle_valid", dout_valid, 64'd0);
        end

        // single transfer
        applyStimulus(37, 8'hA5);
        idleCycles(4);
        checkOutput("single_dout37", 64'(dout[37]), 64'hA5);
        checkOutput("single_others", 64'(countDiff()), 64'd0);

        // streaming through every address, then two back-to-back writes to one output
        for (int i = 0; i < 64; i++) begin
            applyStimulus(i, 8'(i) ^ 8'h3C);
        end
        applyStimulus(5, 8'h11);
        applyStimulus(5, 8'h22);
        idleCycles(4);
        checkOutput("stream_all", 64'(countDiff()), 64'd0);
        checkOutput("stream_dout5", 64'(dout[5]), 64'h22);
        checkOutput("stream_dout63", 64'(dout[63]), 64'(8'd63 ^ 8'h3C));

        // reset while a transfer is in flight discards it
        applyStimulus(12, 8'h77);
        rst       = 1'b1;
        din_valid = 1'b0;
        sb.delete();
        for (int k = 0; k < 64; k++) mdl[k] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idleCycles(5);
        checkOutput("midreset_dout12", 64'(dout[12]), 64'd0);
        checkOutput("midreset_all", 64'(countDiff()), 64'd0);

        // degenerate single-stage tree
        s_adr   = 2'd3;
        s_din   = 8'h5A;
        s_valid = 1'b1;
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        checkOutput("small_valid", 64'(s_dv), 64'b1000);
        checkOutput("small_dout3", 64'(s_dout[3]), 64'h5A);
        checkOutput("small_dout0", 64'(s_dout[0]), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("small_pulse", 64'(s_dv), 64'd0);

        // out-of-range address on the N=24 instance is dropped
        e_adr   = 5'd30;
        e_din   = 8'h99;
        e_valid = 1'b1;
        @(posedge clk);
        #1;
        e_valid = 1'b0;
`ifdef DEMUX_ADR_CHECK_EN
        checkOutput("oor_adr_err", 64'(e_err), 64'd1);
`endif
        checkOutput("oor_nostrobe1", 64'(e_dv), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("oor_nostrobe2", 64'(e_dv), 64'd0);
        e_adr   = 5'd2;
        e_din   = 8'h42;
        e_valid = 1'b1;
        @(posedge clk);
        #1;
        e_valid = 1'b0;
        checkOutput("odd_early", 64'(e_dv), 64'd0);
        @(posedge clk);
        #1;
        checkOutput("odd_valid", 64'(e_dv), 64'd1 << 2);
        checkOutput("odd_dout2", 64'(e_dout[2]), 64'h42);
        checkOutput("odd_dout23", 64'(e_dout[23]), 64'd0);
`ifdef DEMUX_ADR_CHECK_EN
        checkOutput("oor_sticky", 64'(e_err), 64'd1);
        checkOutput("main_adr_err", 64'(m_err), 64'd0);
`endif

        // let any outstanding expectations resolve, bounded
        for (int i = 0; i < 20 && sb.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput("sb_drained", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
